prau_wb_sched: RTL and testbench

- Issue and writeback scheduler for the posit unit (PRAU).
- Accepts one posit operation per cycle from the decode/offload stage and tracks every in-flight operation in a latency-indexed reservation shift register.
- Stalls issue on writeback-port collisions, non-pipelined divider/sqrt occupancy and quire RAW hazards.
- Emits exactly one writeback strobe per result, with its tag, in the cycle the functional unit's result is valid.
- Generalises the fixed per-unit latency table into parametrised latencies and a configurable depth.

---
 rtl/prau_wb_sched.sv | 199 +++++++++++++++++++
 tb/tb_prau_wb_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/prau_wb_sched.sv
// prau_wb_sched -- issue and writeback scheduler for the posit unit (PRAU).
//
// Every accepted operation with a result is placed in a latency-indexed
// reservation shift register. Slot 0 is the writeback slot: its contents
// drive the wb_* outputs directly. Issue is refused when the target slot
// would collide with an older operation, when the non-pipelined divider/sqrt
// is occupied, or when a quire round would read the quire ahead of an
// in-flight quire MAC.
//
// Optional feature (macro PRAU_WB_BACKPRESSURE_EN): adds wb_ready_i. While a
// writeback is pending and not consumed, the whole slot array holds and issue
// is refused. A flush still clears everything.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   issue_valid_i        operation offered
//   issue_ready_o        operation accepted when valid & ready (combinational)
//   issue_unit_i [2:0]   unit class (0 single-cycle .. 6 qmadd, 7 no-writeback)
//   issue_tag_i          tag returned with the writeback
//   flush_i              kill all in-flight operations
//   wb_valid_o           writeback strobe
//   wb_tag_o, wb_unit_o  tag and unit class of the written-back operation
//   wb_ready_i           writeback consumed (PRAU_WB_BACKPRESSURE_EN only)
//   busy_o               any slot occupied
//   inflight_cnt_o       number of occupied slots

module prau_wb_sched #(
    parameter int POSLEN       = 32,
    parameter int ID_W         = 4,
    parameter int MAX_LAT      = 15,
    parameter int PADD_LAT     = 1,
    parameter int PMUL_LAT     = 1,
    parameter int PDIV_LAT     = 4,
    parameter int PSQRT_LAT    = 5,
    parameter int QROUND_LAT   = 1,
    parameter int QMADD_LAT    = 2,
    parameter int PIPE_DIVSQRT = 0,
    localparam int D           = MAX_LAT + 1,
    localparam int CNT_W       = $clog2(D + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             issue_valid_i,
    output logic             issue_ready_o,
    input  logic [2:0]       issue_unit_i,
    input  logic [ID_W-1:0]  issue_tag_i,
    input  logic             flush_i,
`ifdef PRAU_WB_BACKPRESSURE_EN
    input  logic             wb_ready_i,
`endif
    output logic             wb_valid_o,
    output logic [ID_W-1:0]  wb_tag_o,
    output logic [2:0]       wb_unit_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] inflight_cnt_o
);

    localparam int IDX_W = (D > 1) ? $clog2(D) : 1;

    localparam logic [2:0] U_SC     = 3'd0;
    localparam logic [2:0] U_ADD    = 3'd1;
    localparam logic [2:0] U_MUL    = 3'd2;
    localparam logic [2:0] U_DIV    = 3'd3;
    localparam logic [2:0] U_SQRT   = 3'd4;
    localparam logic [2:0] U_QROUND = 3'd5;
    localparam logic [2:0] U_QMADD  = 3'd6;

    // A unit latency that does not fit the reservation depth is a
    // configuration error, caught at elaboration.
    if (POSLEN < 1 || ID_W < 1 ||
        PADD_LAT   < 0 || PADD_LAT   > MAX_LAT ||
        PMUL_LAT   < 0 || PMUL_LAT   > MAX_LAT ||
        PDIV_LAT   < 0 || PDIV_LAT   > MAX_LAT ||
        PSQRT_LAT  < 0 || PSQRT_LAT  > MAX_LAT ||
        QROUND_LAT < 0 || QROUND_LAT > MAX_LAT ||
        QMADD_LAT  < 0 || QMADD_LAT  > MAX_LAT) begin : g_bad_cfg
        $error("prau_wb_sched: unit latency outside 0..MAX_LAT");
    end

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] tag;
        logic [2:0]      unit;
    } slot_t;

    slot_t [D-1:0]    slot_q, slot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q;

    logic [IDX_W-1:0] lat;
    logic             lat_bad;
    logic             no_wb;
    logic [D-1:0]     col_vec;
    logic             collision;
    logic             div_occ;
    logic             q_occ;
    logic             div_block;
    logic             q_block;
    logic             stall;
    logic             accept;

    // Unit class -> latency. Unit 7 has no result and never takes a slot.
    always_comb begin
        int lat_int;
        lat_int = 0;
        no_wb   = 1'b0;
        case (issue_unit_i)
            U_SC:     lat_int = 0;
            U_ADD:    lat_int = PADD_LAT;
            U_MUL:    lat_int = PMUL_LAT;
            U_DIV:    lat_int = PDIV_LAT;
            U_SQRT:   lat_int = PSQRT_LAT;
            U_QROUND: lat_int = QROUND_LAT;
            U_QMADD:  lat_int = QMADD_LAT;
            default:  no_wb   = 1'b1;
        endcase
        lat_bad = (lat_int > MAX_LAT);
        lat     = lat_bad ? '0 : IDX_W'(lat_int);
    end

    // col_vec[k]: a new op of latency k would land on S[k+1] as it shifts
    // down into S[k]. The top slot is always refilled with invalid.
    always_comb begin
        col_vec = '0;
        for (int k = 0; k < D - 1; k++) begin
            col_vec[k] = slot_q[k+1].valid;
        end
    end

    assign collision = col_vec[lat] & ~no_wb;

    // Occupancy scans include S[0]: an op writing back this cycle still
    // owns its unit (divider) or the quire (MAC result not yet committed).
    always_comb begin
        div_occ = 1'b0;
        q_occ   = 1'b0;
        for (int i = 0; i < D; i++) begin
            if (slot_q[i].valid && (slot_q[i].unit == U_DIV || slot_q[i].unit == U_SQRT))
                div_occ = 1'b1;
            if (slot_q[i].valid && slot_q[i].unit == U_QMADD)
                q_occ = 1'b1;
        end
    end

    assign div_block = (PIPE_DIVSQRT == 0) &&
                       (issue_unit_i == U_DIV || issue_unit_i == U_SQRT) && div_occ;
    assign q_block   = (issue_unit_i == U_QROUND) && q_occ;

`ifdef PRAU_WB_BACKPRESSURE_EN
    // Unconsumed writeback freezes the array; flush takes precedence.
    assign stall = slot_q[0].valid & ~wb_ready_i & ~flush_i;
`else
    assign stall = 1'b0;
`endif

    assign issue_ready_o = ~flush_i & ~stall & ~lat_bad & ~collision & ~div_block & ~q_block;
    assign accept        = issue_valid_i & issue_ready_o;

    // Next state: shift (unless stalled), insert the accepted op at S[lat],
    // flush clears everything. The count tracks the resulting array.
    always_comb begin
        slot_d = slot_q;
        if (!stall) begin
            for (int i = 0; i < D - 1; i++) begin
                slot_d[i] = slot_q[i+1];
            end
            slot_d[D-1] = '0;
        end
        if (accept && !no_wb) begin
            slot_d[lat] = '{valid: 1'b1, tag: issue_tag_i, unit: issue_unit_i};
        end
        if (flush_i) begin
            slot_d = '0;
        end
        cnt_d = '0;
        for (int i = 0; i < D; i++) begin
            cnt_d = cnt_d + CNT_W'(slot_d[i].valid);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
            busy_q <= (cnt_d != '0);
        end
    end

    assign wb_valid_o     = slot_q[0].valid;
    assign wb_tag_o       = slot_q[0].tag;
    assign wb_unit_o      = slot_q[0].unit;
    assign busy_o         = busy_q;
    assign inflight_cnt_o = cnt_q;

endmodule

// File: tb/tb_prau_wb_sched.sv
// Directed testbench for prau_wb_sched (default parameters, PIPE_DIVSQRT=0).
// Inputs change just after the falling edge; checks run 1 time unit later,
// well clear of the rising edge.

module tb_prau_wb_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid;
    logic       issue_ready;
    logic [2:0] issue_unit;
    logic [3:0] issue_tag;
    logic       flush;
    logic       wb_valid;
    logic [3:0] wb_tag;
    logic [2:0] wb_unit;
    logic       busy;
    logic [4:0] cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    prau_wb_sched dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .issue_valid_i  (issue_valid),
        .issue_ready_o  (issue_ready),
        .issue_unit_i   (issue_unit),
        .issue_tag_i    (issue_tag),
        .flush_i        (flush),
`ifdef PRAU_WB_BACKPRESSURE_EN
        .wb_ready_i     (1'b1),
`endif
        .wb_valid_o     (wb_valid),
        .wb_tag_o       (wb_tag),
        .wb_unit_o      (wb_unit),
        .busy_o         (busy),
        .inflight_cnt_o (cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] u, input logic [3:0] t, input logic f);
        @(negedge clk);
        issue_valid = v;
        issue_unit  = u;
        issue_tag   = t;
        flush       = f;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 4'd0, 1'b0);
    endtask

    task automatic chk_wb(input string tag, input logic v, input logic [3:0] t, input logic [2:0] u);
        chk({tag, "_wbv"}, 32'(wb_valid), 32'(v));
        if (v) begin
            chk({tag, "_wbtag"}, 32'(wb_tag), 32'(t));
            chk({tag, "_wbunit"}, 32'(wb_unit), 32'(u));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_unit  = 3'd0;
        issue_tag   = 4'd0;
        flush       = 1'b0;

        // Reset held 5 cycles, then released.
        repeat (5) @(negedge clk);
        #1;
        chk("rst_hold_cnt", 32'(cnt), 0);
        chk("rst_hold_wbv", 32'(wb_valid), 0);
        @(negedge clk);
        rst_n      = 1'b1;
        issue_unit = 3'd1;
        #1;
        chk("rst_wbv",   32'(wb_valid), 0);
        chk("rst_wbtag", 32'(wb_tag), 0);
        chk("rst_wbunit",32'(wb_unit), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_cnt",   32'(cnt), 0);
        chk("rst_rdy",   32'(issue_ready), 1);

        // Add, tag 3: writeback two cycles after issue, busy for two cycles.
        drive(1'b1, 3'd1, 4'd3, 1'b0);
        chk("add_rdy", 32'(issue_ready), 1);
        chk_wb("add_c0", 1'b0, 4'd0, 3'd0);
        idle();
        chk_wb("add_c1", 1'b0, 4'd0, 3'd0);
        chk("add_c1_busy", 32'(busy), 1);
        chk("add_c1_cnt",  32'(cnt), 1);
        idle();
        chk_wb("add_c2", 1'b1, 4'd3, 3'd1);
        chk("add_c2_busy", 32'(busy), 1);
        idle();
        chk_wb("add_c3", 1'b0, 4'd0, 3'd0);
        chk("add_c3_busy", 32'(busy), 0);
        chk("add_c3_cnt",  32'(cnt), 0);

        // Div tag 1, then add tag 2 collides at c3; mul tag 7 joins at c5
        // in the same cycle as the div writeback.
        drive(1'b1, 3'd3, 4'd1, 1'b0);
        chk("col_div_rdy", 32'(issue_ready), 1);
        idle();
        chk("col_c1_cnt", 32'(cnt), 1);
        idle();
        drive(1'b1, 3'd1, 4'd2, 1'b0);
        chk("col_add_blk", 32'(issue_ready), 0);
        issue_valid = 1'b0;
        issue_unit  = 3'd0;
        #1;
        chk("col_other_lat_rdy", 32'(issue_ready), 1);
        drive(1'b1, 3'd1, 4'd2, 1'b0);
        chk("col_add_acc", 32'(issue_ready), 1);
        drive(1'b1, 3'd2, 4'd7, 1'b0);
        chk("col_mul_rdy", 32'(issue_ready), 1);
        chk_wb("col_c5", 1'b1, 4'd1, 3'd3);
        chk("col_c5_cnt", 32'(cnt), 2);
        idle();
        chk_wb("col_c6", 1'b1, 4'd2, 3'd1);
        chk("col_c6_cnt", 32'(cnt), 2);
        idle();
        chk_wb("col_c7", 1'b1, 4'd7, 3'd2);
        chk("col_c7_cnt", 32'(cnt), 1);
        idle();
        chk_wb("col_c8", 1'b0, 4'd0, 3'd0);
        chk("col_c8_cnt", 32'(cnt), 0);

        // Divider occupancy: sqrt waits until the div has fully drained.
        drive(1'b1, 3'd3, 4'd1, 1'b0);
        chk("dv_div_rdy", 32'(issue_ready), 1);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 3'd4, 4'd2, 1'b0);
            chk("dv_sqrt_blk", 32'(issue_ready), 0);
            if (k == 2) begin
                issue_unit = 3'd7;
                #1;
                chk("dv_u7_rdy", 32'(issue_ready), 1);
                issue_unit = 3'd4;
                #1;
            end
        end
        drive(1'b1, 3'd4, 4'd2, 1'b0);
        chk("dv_c5_blk", 32'(issue_ready), 0);
        chk_wb("dv_c5", 1'b1, 4'd1, 3'd3);
        drive(1'b1, 3'd4, 4'd2, 1'b0);
        chk("dv_c6_acc", 32'(issue_ready), 1);
        chk_wb("dv_c6", 1'b0, 4'd0, 3'd0);
        for (int k = 7; k <= 11; k++) begin
            idle();
            chk_wb("dv_wait", 1'b0, 4'd0, 3'd0);
        end
        idle();
        chk_wb("dv_c12", 1'b1, 4'd2, 3'd4);
        idle();
        chk_wb("dv_c13", 1'b0, 4'd0, 3'd0);
        chk("dv_c13_cnt", 32'(cnt), 0);

        // Quire hazard: qround waits while a qmadd holds any slot.
        drive(1'b1, 3'd6, 4'd5, 1'b0);
        chk("q_mac_rdy", 32'(issue_ready), 1);
        drive(1'b1, 3'd5, 4'd6, 1'b0);
        chk("q_c1_blk", 32'(issue_ready), 0);
        drive(1'b1, 3'd5, 4'd6, 1'b0);
        chk("q_c2_blk", 32'(issue_ready), 0);
        drive(1'b1, 3'd5, 4'd6, 1'b0);
        chk("q_c3_blk", 32'(issue_ready), 0);
        chk_wb("q_c3", 1'b1, 4'd5, 3'd6);
        drive(1'b1, 3'd5, 4'd6, 1'b0);
        chk("q_c4_acc", 32'(issue_ready), 1);
        idle();
        chk_wb("q_c5", 1'b0, 4'd0, 3'd0);
        idle();
        chk_wb("q_c6", 1'b1, 4'd6, 3'd5);
        idle();
        chk_wb("q_c7", 1'b0, 4'd0, 3'd0);

        // Flush with three ops in flight; the S[0] writeback of the flush
        // cycle is still visible, nothing afterwards.
        drive(1'b1, 3'd3, 4'd8, 1'b0);
        chk("fl_div_rdy", 32'(issue_ready), 1);
        drive(1'b1, 3'd6, 4'd9, 1'b0);
        chk("fl_mac_rdy", 32'(issue_ready), 1);
        drive(1'b1, 3'd0, 4'd10, 1'b0);
        chk("fl_sc_rdy", 32'(issue_ready), 1);
        drive(1'b1, 3'd1, 4'd11, 1'b1);
        chk("fl_rdy", 32'(issue_ready), 0);
        chk_wb("fl_c3", 1'b1, 4'd10, 3'd0);
        chk("fl_c3_cnt",  32'(cnt), 3);
        chk("fl_c3_busy", 32'(busy), 1);
        idle();
        chk("fl_c4_cnt",  32'(cnt), 0);
        chk("fl_c4_busy", 32'(busy), 0);
        chk_wb("fl_c4", 1'b0, 4'd0, 3'd0);
        for (int k = 5; k <= 9; k++) begin
            idle();
            chk_wb("fl_after", 1'b0, 4'd0, 3'd0);
        end

        // Asynchronous reset mid-operation drops the in-flight sqrt.
        drive(1'b1, 3'd4, 4'd12, 1'b0);
        chk("ar_rdy", 32'(issue_ready), 1);
        idle();
        chk("ar_cnt_before", 32'(cnt), 1);
        rst_n = 1'b0;
        #1;
        chk("ar_cnt",  32'(cnt), 0);
        chk("ar_busy", 32'(busy), 0);
        chk_wb("ar_now", 1'b0, 4'd0, 3'd0);
        idle();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            idle();
            chk_wb("ar_after", 1'b0, 4'd0, 3'd0);
        end
        chk("ar_end_cnt", 32'(cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
